// File: rtl/i2s_mix_n.sv
// i2s_mix_n: N-channel bit-serial I2S mixer.
// Deserialises n_ch I2S lines sharing one bclk/lrclk pair, applies per-channel
// shift/negate/mute, sums the channels and re-serialises the mix one half-frame later.
// Optional feature macro MIX_SAT_EN: clamp the mix to w_out bits and drive a sticky
// saturation flag; without it the mix wraps and sat_o is tied low.
module i2s_mix_n #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned W_SMP     = 32,
    parameter int unsigned W_IN      = 24,
    parameter int unsigned W_OUT     = 24,
    parameter int unsigned MAX_SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk_i,
    input  logic              lrclk_i,
    input  logic [N_CH-1:0]   in_i,
    input  logic [4*N_CH-1:0] shift_i,
    input  logic [N_CH-1:0]   minus_i,
    input  logic [N_CH-1:0]   mute_i,
    output logic              out_o,
    output logic              sat_o
);

    localparam int unsigned CNT_W = (W_SMP > 1) ? $clog2(W_SMP) : 1;
    localparam int unsigned W_MAX = (W_OUT > W_IN) ? W_OUT : W_IN;
    // Wide enough for the full channel sum plus the clamp comparison
    localparam int unsigned ACC_W = W_MAX + $clog2(N_CH) + 2;
    localparam int unsigned DROP  = (W_OUT < W_IN) ? (W_IN - W_OUT) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(W_SMP - 1);
    localparam logic [3:0]       SHIFT_CAP = (MAX_SHIFT > 15) ? 4'hF : 4'(MAX_SHIFT);

    // Synchronisers / edge detection
    logic [1:0]          bclk_q;
    logic                lr_q;
    logic [N_CH-1:0]     in_q;
    logic                rise_c;
    logic                fall_c;
    logic                bound_c;

    // Framing and datapath state
    logic                lr_prev_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [W_IN-1:0]     cap_q [N_CH];
    logic [W_OUT-1:0]    held_q;
    logic                first_q;
    logic                out_q;
    logic                out_bit_c;

    // Mix datapath
    logic [3:0]              sh_amt;
    logic signed [ACC_W-1:0] val;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] algn_c;
    logic [W_OUT-1:0]        word_c;

`ifdef MIX_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    logic clamp_c;
    logic sat_q;
`endif

    assign rise_c  = bclk_q[0] & ~bclk_q[1];
    assign fall_c  = ~bclk_q[0] & bclk_q[1];
    assign bound_c = rise_c & (lr_q != lr_prev_q);

    // Input synchronisers; lrclk/data follow the first bclk stage so they align with rise_c
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q <= 2'b00;
            lr_q   <= 1'b0;
            in_q   <= '0;
        end else begin
            bclk_q <= {bclk_q[0], bclk_i};
            lr_q   <= lrclk_i;
            in_q   <= in_i;
        end
    end

    // Next bit counter: cleared at a boundary, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (bound_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Framing state: previous lrclk sample and bit counter, advanced on each rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else if (rise_c) begin
            lr_prev_q <= lr_q;
            cnt_q     <= cnt_d;
        end
    end

    // Capture MSB-first bits at counts 1..W_IN; clear after the boundary transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                cap_q[i] <= '0;
            end
        end else if (bound_c) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                cap_q[i] <= '0;
            end
        end else if (rise_c) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                for (int k = 1; k <= int'(W_IN); k++) begin
                    if (cnt_d == CNT_W'(k)) begin
                        cap_q[i][W_IN-k] <= in_q[i];
                    end
                end
            end
        end
    end

    // Per-channel shift/negate/mute and channel sum, aligned to the output width
    always_comb begin
        sh_amt = '0;
        val    = '0;
        sum_c  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            sh_amt = shift_i[4*i +: 4];
            if (sh_amt > SHIFT_CAP) begin
                sh_amt = SHIFT_CAP;
            end
            val = ACC_W'($signed(cap_q[i]));
            val = val >>> sh_amt;
            if (minus_i[i]) begin
                val = -val;
            end
            if (mute_i[i]) begin
                val = '0;
            end
            sum_c = sum_c + val;
        end
        algn_c = sum_c >>> DROP;
    end

    // Reduce the aligned sum to the output word
    always_comb begin
`ifdef MIX_SAT_EN
        clamp_c = 1'b0;
        if (algn_c > SAT_HI) begin
            word_c  = W_OUT'(SAT_HI);
            clamp_c = 1'b1;
        end else if (algn_c < SAT_LO) begin
            word_c  = W_OUT'(SAT_LO);
            clamp_c = 1'b1;
        end else begin
            word_c  = W_OUT'(algn_c);
        end
`else
        word_c = W_OUT'(algn_c);
`endif
    end

    // Held output word: loaded at each boundary; the first boundary after reset loads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= '0;
            first_q <= 1'b1;
        end else if (bound_c) begin
            held_q  <= first_q ? '0 : word_c;
            first_q <= 1'b0;
        end
    end

    // Select the output bit for the counter seen at the preceding rise
    always_comb begin
        out_bit_c = 1'b0;
        for (int k = 1; k <= int'(W_OUT); k++) begin
            if (cnt_q == CNT_W'(k)) begin
                out_bit_c = held_q[W_OUT-k];
            end
        end
    end

    // Serial output register, updated on each bclk fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else if (fall_c) begin
            out_q <= out_bit_c;
        end
    end

    assign out_o = out_q;

`ifdef MIX_SAT_EN
    // Sticky saturation flag, set whenever a loaded mix was clamped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (bound_c && !first_q && clamp_c) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mix_n.sv
// tb_i2s_mix_n: scoreboard bench for i2s_mix_n; honours MIX_SAT_EN like the design.
`timescale 1ns/1ps
module tb_i2s_mix_n;

    localparam int N_CH      = 4;
    localparam int W_SMP     = 32;
    localparam int W_IN      = 24;
    localparam int W_OUT     = 24;
    localparam int MAX_SHIFT = 8;
    localparam int HB        = 40;   // bclk half period, 8 clk periods per bclk

    typedef struct {
        logic [W_OUT-1:0] word;
        bit               sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bclk;
    logic              lrclk;
    logic [N_CH-1:0]   in_s;
    logic [4*N_CH-1:0] shift_s;
    logic [N_CH-1:0]   minus_s;
    logic [N_CH-1:0]   mute_s;
    logic              out_o;
    logic              sat_o;

    i2s_mix_n #(
        .N_CH(N_CH), .W_SMP(W_SMP), .W_IN(W_IN), .W_OUT(W_OUT), .MAX_SHIFT(MAX_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bclk_i(bclk), .lrclk_i(lrclk), .in_i(in_s),
        .shift_i(shift_s), .minus_i(minus_s), .mute_i(mute_s), .out_o(out_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   pushed = 0;
    int   popped = 0;

    // Reference model state
    logic [W_IN-1:0]   smp [N_CH];
    logic [4*N_CH-1:0] n_shift;
    logic [N_CH-1:0]   n_minus;
    logic [N_CH-1:0]   n_mute;
    int                seg_no;
    bit                sat_m;
    logic [W_OUT-1:0]  pend_w;
    bit                pend_c;

    task automatic push_exp(input logic [W_OUT-1:0] w, input bit s);
        exp_t e;
        e.word = w;
        e.sat  = s;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Expected word for the segment that begins at this lrclk change
    task automatic start_segment();
        seg_no++;
        if (seg_no == 1) begin
            push_exp('0, sat_m);
        end else begin
            sat_m = sat_m | pend_c;
            push_exp(pend_w, sat_m);
        end
    endtask

    // Mix of the segment just driven (L rises), using the controls present at its end
    task automatic model_mix(input int L);
        longint acc;
        longint v;
        longint hi;
        longint lo;
        int     nb;
        int     s;
        acc = 0;
        nb  = (L - 1 < W_IN) ? L - 1 : W_IN;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!mute_s[ch]) begin
                v = longint'(smp[ch]);
                v = (v >> (W_IN - nb)) << (W_IN - nb);
                if (v >= (64'sd1 <<< (W_IN - 1))) v = v - (64'sd1 <<< W_IN);
                s = int'(shift_s[4*ch +: 4]);
                if (s > MAX_SHIFT) s = MAX_SHIFT;
                v = v >>> s;
                if (minus_s[ch]) v = -v;
                acc = acc + v;
            end
        end
        if (W_OUT < W_IN) acc = acc >>> (W_IN - W_OUT);
        hi = (64'sd1 <<< (W_OUT - 1)) - 1;
        lo = -(64'sd1 <<< (W_OUT - 1));
        pend_c = 1'b0;
`ifdef MIX_SAT_EN
        if (acc > hi) begin
            acc = hi;
            pend_c = 1'b1;
        end else if (acc < lo) begin
            acc = lo;
            pend_c = 1'b1;
        end
`endif
        pend_w = W_OUT'(acc);
    endtask

    // Drive one half-frame of L bclk cycles with the opposite lrclk value
    task automatic drive_half(input int L);
        for (int k = 0; k < L; k++) begin
            if (k == 0) begin
                lrclk = ~lrclk;
                start_segment();
            end
            if (k == L / 2) begin
                shift_s = n_shift;
                minus_s = n_minus;
                mute_s  = n_mute;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                in_s[ch] = (k >= 1 && k <= W_IN) ? smp[ch][W_IN-k] : 1'($urandom);
            end
            #HB bclk = 1'b1;
            #HB bclk = 1'b0;
        end
        model_mix(L);
    endtask

    task automatic rand_samples();
        for (int ch = 0; ch < N_CH; ch++) smp[ch] = W_IN'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (out_o !== 1'b0 || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: out=%b sat=%b, required out=0 sat=0", tag, out_o, sat_o);
        end
    endtask

    // Monitor: reassemble each transmitted segment and compare at the next boundary
    int               m_pos = 0;
    int               m_nbits = 0;
    bit               m_lr = 1'b0;
    bit               m_pad_bad = 1'b0;
    logic [W_OUT-1:0] m_acc = '0;

    task automatic finalize_seg();
        exp_t             e;
        logic [W_OUT-1:0] got;
        logic [W_OUT-1:0] want;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: segment received with no expected word (got %h)", m_acc);
        end else begin
            e = exp_q.pop_front();
            popped++;
            got  = m_acc >> (W_OUT - m_nbits);
            want = e.word >> (W_OUT - m_nbits);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL word seg%0d: got %h required %h (%0d bits)", popped, got, want, m_nbits);
            end
            checks++;
            if (sat_o !== e.sat) begin
                errors++;
                $display("FAIL sat seg%0d: got %b required %b", popped, sat_o, e.sat);
            end
            checks++;
            if (m_pad_bad) begin
                errors++;
                $display("FAIL pad seg%0d: got nonzero bit at position 0 or above %0d, required 0", popped, W_OUT);
            end
        end
    endtask

    always @(posedge bclk) begin
        if (!rst_n) begin
            m_pos = 0; m_lr = 1'b0; m_nbits = 0; m_pad_bad = 1'b0; m_acc = '0;
        end else begin
            if (m_pos >= 1 && m_pos <= W_OUT) begin
                m_acc[W_OUT-m_pos] = out_o;
                m_nbits++;
            end else if (out_o !== 1'b0) begin
                m_pad_bad = 1'b1;
            end
            if (lrclk != m_lr) begin
                finalize_seg();
                m_pos = 0; m_nbits = 0; m_pad_bad = 1'b0; m_acc = '0;
                m_lr = lrclk;
            end else if (m_pos < W_SMP - 1) begin
                m_pos++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; in_s = '0;
        shift_s = '0; minus_s = '0; mute_s = '0;
        n_shift = '0; n_minus = '0; n_mute = '0;
        seg_no = 0; sat_m = 1'b0; pend_w = '0; pend_c = 1'b0;
        rand_samples();
        #23;
        check_reset_outputs("reset_initial");
        rst_n = 1'b1;
        push_exp('0, 1'b0);

        // Filler right slot, then passthrough of ch0 on the left slot
        drive_half(32);
        smp[0] = 24'h123456; n_shift = '0; n_minus = '0; n_mute = 4'b1110;
        drive_half(32);
        // Shift and negate
        rand_samples();
        smp[0] = 24'h100000; smp[1] = 24'h040000;
        n_shift = 16'h0004; n_minus = 4'b0010; n_mute = 4'b1100;
        drive_half(32);
        // Shift beyond the cap on a negative extreme
        rand_samples();
        smp[0] = 24'h800000; n_shift = 16'h000F; n_minus = '0; n_mute = 4'b1110;
        drive_half(32);
        // Randomised frames at nominal length
        for (int f = 0; f < 16; f++) begin
            rand_samples();
            n_shift = 16'($urandom); n_minus = 4'($urandom); n_mute = 4'($urandom);
            drive_half(32);
        end
        // Short and long frames, then random lengths
        rand_samples(); n_mute = 4'b0000; n_shift = '0; n_minus = '0;
        drive_half(12);
        rand_samples();
        drive_half(40);
        drive_half(32);
        for (int f = 0; f < 10; f++) begin
            rand_samples();
            n_shift = 16'($urandom); n_minus = 4'($urandom); n_mute = 4'($urandom);
            drive_half($urandom_range(12, 40));
        end
        // Positive overflow, then a silent frame to show sat stays set
        for (int ch = 0; ch < N_CH; ch++) smp[ch] = 24'h7FFFFF;
        n_shift = '0; n_minus = '0; n_mute = '0;
        drive_half(32);
        rand_samples(); n_mute = 4'b1111;
        drive_half(32);
        drive_half(32);
        // Negation of the most negative sample
        rand_samples(); smp[0] = 24'h800000; n_minus = 4'b0001; n_mute = 4'b1110;
        drive_half(32);
        drive_half(32);

        // Reset in the middle of a left slot with all-ones input
        if (lrclk == 1'b0) drive_half(32);
        for (int k = 0; k < 32; k++) begin
            if (k == 0) begin
                lrclk = 1'b0;
                start_segment();
            end
            in_s = '1;
            if (k == 4) begin
                rst_n = 1'b0;
                exp_q.delete();
                pushed = 0; popped = 0;
                #1 check_reset_outputs("reset_midframe");
                #(HB - 1) bclk = 1'b1;
            end else begin
                if (k == 10) begin
                    rst_n = 1'b1;
                    seg_no = 0; sat_m = 1'b0; pend_c = 1'b0;
                    push_exp('0, 1'b0);
                end
                #HB bclk = 1'b1;
            end
            #HB bclk = 1'b0;
        end
        n_shift = '0; n_minus = '0; n_mute = '0;
        for (int f = 0; f < 4; f++) begin
            rand_samples();
            n_shift = 16'($urandom); n_minus = 4'($urandom); n_mute = 4'($urandom);
            drive_half(32);
        end
        drive_half(2);

        // Every segment except the one still in flight must have been compared
        checks++;
        if (popped != pushed - 1) begin
            errors++;
            $display("FAIL segment_count: compared %0d required %0d", popped, pushed - 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
